// File: rtl/lab6_countdown_timer.sv
// -----------------------------------------------------------------------------
// lab6_countdown_timer
//   MM:SS BCD countdown timer in the slow clk_tmp domain. Two raw pushbuttons
//   are debounced and turned into single-cycle pulses. clk_tmp is prescaled to
//   a 1 s tick, and a four-state FSM (IDLE/RUN/PAUSE/DONE) counts the BCD
//   digits down to 00:00.
//
// Ports
//   clk_tmp   in   slow clock from the frequency divider (posedge logic)
//   rst_n     in   asynchronous active-low reset
//   pb_start  in   raw start/pause pushbutton, active-high, may bounce
//   pb_clr    in   raw clear pushbutton, active-high, may bounce
//   min_tens  out  BCD minutes tens digit
//   min_ones  out  BCD minutes ones digit
//   sec_tens  out  BCD seconds tens digit (0..5)
//   sec_ones  out  BCD seconds ones digit
//   running   out  high while in RUN
//   done      out  high while in DONE
// -----------------------------------------------------------------------------
module lab6_countdown_timer #(
    parameter int TICK_DIV = 100,
    parameter int DEB_LEN  = 4,
    parameter int INIT_MIN = 1,
    parameter int INIT_SEC = 30
) (
    input  logic       clk_tmp,
    input  logic       rst_n,
    input  logic       pb_start,
    input  logic       pb_clr,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [15:0] PRESET = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                      4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};
    localparam logic [15:0] ZERO_TIME = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One-second BCD decrement with ripple borrow; never called on 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       b;
        mt = d[15:12];
        mo = d[11:8];
        st = d[7:4];
        so = d[3:0];
        if (so == 4'd0) begin
            so = 4'd9;
            b  = 1'b1;
        end else begin
            so = so - 4'd1;
            b  = 1'b0;
        end
        if (b) begin
            if (st == 4'd0) begin
                st = 4'd5;
            end else begin
                st = st - 4'd1;
                b  = 1'b0;
            end
        end
        if (b) begin
            if (mo == 4'd0) begin
                mo = 4'd9;
            end else begin
                mo = mo - 4'd1;
                b  = 1'b0;
            end
        end
        if (b) begin
            mt = mt - 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    logic [DEB_LEN-1:0] start_sr_r;
    logic [DEB_LEN-1:0] clr_sr_r;
    logic               start_deb_d_r;
    logic               clr_deb_d_r;
    logic               start_pulse_r;
    logic               clr_pulse_r;
    logic               start_deb_s;
    logic               clr_deb_s;

    state_t             state_r;
    logic [15:0]        digits_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               running_r;
    logic               done_r;
    logic               tick_s;
    logic [15:0]        dec_s;

    // A button counts as pressed only when every sample in the window is high.
    assign start_deb_s = &start_sr_r;
    assign clr_deb_s   = &clr_sr_r;

    // Debounce shift registers and rising-edge pulse generation for both buttons.
    always_ff @(posedge clk_tmp or negedge rst_n) begin
        if (!rst_n) begin
            start_sr_r    <= {DEB_LEN{1'b0}};
            clr_sr_r      <= {DEB_LEN{1'b0}};
            start_deb_d_r <= 1'b0;
            clr_deb_d_r   <= 1'b0;
            start_pulse_r <= 1'b0;
            clr_pulse_r   <= 1'b0;
        end else begin
            start_sr_r    <= {start_sr_r[DEB_LEN-2:0], pb_start};
            clr_sr_r      <= {clr_sr_r[DEB_LEN-2:0], pb_clr};
            start_deb_d_r <= start_deb_s;
            clr_deb_d_r   <= clr_deb_s;
            start_pulse_r <= start_deb_s & ~start_deb_d_r;
            clr_pulse_r   <= clr_deb_s & ~clr_deb_d_r;
        end
    end

    assign tick_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    assign dec_s  = bcd_dec(digits_r);

    // Timer FSM: state, digits, prescaler and registered status flags.
    always_ff @(posedge clk_tmp or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            digits_r  <= PRESET;
            cnt_r     <= CNT_ZERO;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else if (clr_pulse_r) begin
            // Clear wins over start in every state.
            state_r   <= ST_IDLE;
            digits_r  <= PRESET;
            cnt_r     <= CNT_ZERO;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    digits_r <= PRESET;
                    cnt_r    <= CNT_ZERO;
                    if (start_pulse_r) begin
                        if (PRESET == ZERO_TIME) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        // Decrement still lands when start arrives on the tick edge.
                        cnt_r    <= CNT_ZERO;
                        digits_r <= dec_s;
                        if (dec_s == ZERO_TIME) begin
                            state_r   <= ST_DONE;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else if (start_pulse_r) begin
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (start_pulse_r) begin
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    // Prescaler keeps its value so the partial second resumes.
                    if (start_pulse_r) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    digits_r <= ZERO_TIME;
                    cnt_r    <= CNT_ZERO;
                    if (start_pulse_r) begin
                        state_r  <= ST_IDLE;
                        digits_r <= PRESET;
                        done_r   <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    digits_r  <= PRESET;
                    cnt_r     <= CNT_ZERO;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign min_tens = digits_r[15:12];
    assign min_ones = digits_r[11:8];
    assign sec_tens = digits_r[7:4];
    assign sec_ones = digits_r[3:0];
    assign running  = running_r;
    assign done     = done_r;

endmodule

// File: tb/tb_lab6_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_lab6_countdown_timer
//   Four timer instances (presets 01:30, 10:00, 00:00, 00:02; 4-cycle tick)
//   share the clock, reset and buttons. A behavioural model keeps each timer
//   as an integer number of remaining seconds plus a prescaler count, and the
//   buttons as run lengths of consecutive high samples.
// -----------------------------------------------------------------------------
module tb_lab6_countdown_timer;

    localparam int TD  = 4;
    localparam int DEB = 4;
    localparam int NI  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk_tmp;
    logic       rst_n;
    logic       pb_start;
    logic       pb_clr;
    logic [3:0] mt [NI];
    logic [3:0] mo [NI];
    logic [3:0] st [NI];
    logic [3:0] so [NI];
    logic       run_o [NI];
    logic       done_o [NI];

    int preset [NI] = '{90, 600, 0, 2};

    int m_state [NI];
    int m_rem   [NI];
    int m_cnt   [NI];
    int s_run;
    int c_run;
    bit s_deb_d;
    bit c_deb_d;
    bit s_p;
    bit c_p;

    int n_cmp = 0;
    int n_err = 0;

    lab6_countdown_timer #(.TICK_DIV(TD), .DEB_LEN(DEB), .INIT_MIN(1), .INIT_SEC(30)) u_t0 (
        .clk_tmp(clk_tmp), .rst_n(rst_n), .pb_start(pb_start), .pb_clr(pb_clr),
        .min_tens(mt[0]), .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
        .running(run_o[0]), .done(done_o[0]));

    lab6_countdown_timer #(.TICK_DIV(TD), .DEB_LEN(DEB), .INIT_MIN(10), .INIT_SEC(0)) u_t1 (
        .clk_tmp(clk_tmp), .rst_n(rst_n), .pb_start(pb_start), .pb_clr(pb_clr),
        .min_tens(mt[1]), .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
        .running(run_o[1]), .done(done_o[1]));

    lab6_countdown_timer #(.TICK_DIV(TD), .DEB_LEN(DEB), .INIT_MIN(0), .INIT_SEC(0)) u_t2 (
        .clk_tmp(clk_tmp), .rst_n(rst_n), .pb_start(pb_start), .pb_clr(pb_clr),
        .min_tens(mt[2]), .min_ones(mo[2]), .sec_tens(st[2]), .sec_ones(so[2]),
        .running(run_o[2]), .done(done_o[2]));

    lab6_countdown_timer #(.TICK_DIV(TD), .DEB_LEN(DEB), .INIT_MIN(0), .INIT_SEC(2)) u_t3 (
        .clk_tmp(clk_tmp), .rst_n(rst_n), .pb_start(pb_start), .pb_clr(pb_clr),
        .min_tens(mt[3]), .min_ones(mo[3]), .sec_tens(st[3]), .sec_ones(so[3]),
        .running(run_o[3]), .done(done_o[3]));

    initial clk_tmp = 1'b0;
    always #5 clk_tmp = ~clk_tmp;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Seconds -> packed BCD MM:SS as four nibbles.
    function automatic int exp_dig(input int r);
        int m;
        int s;
        m = r / 60;
        s = r % 60;
        return (m / 10) * 4096 + (m % 10) * 256 + (s / 10) * 16 + (s % 10);
    endfunction

    function automatic int dut_dig(input int k);
        return int'({mt[k], mo[k], st[k], so[k]});
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_state[k] = M_IDLE;
            m_rem[k]   = preset[k];
            m_cnt[k]   = 0;
        end
        s_run = 0;
        c_run = 0;
        s_deb_d = 1'b0;
        c_deb_d = 1'b0;
        s_p = 1'b0;
        c_p = 1'b0;
    endtask

    // One clock edge of the reference: the timers react to the pulses issued
    // on the previous edge, then the button pulses are recomputed from the
    // run lengths of consecutive high samples.
    task automatic model_step(input logic s, input logic c);
        bit s_deb;
        bit c_deb;
        for (int k = 0; k < NI; k++) begin
            if (c_p) begin
                m_state[k] = M_IDLE;
                m_rem[k]   = preset[k];
                m_cnt[k]   = 0;
            end else begin
                case (m_state[k])
                    M_IDLE: begin
                        m_rem[k] = preset[k];
                        m_cnt[k] = 0;
                        if (s_p) m_state[k] = (preset[k] == 0) ? M_DONE : M_RUN;
                    end
                    M_RUN: begin
                        if (m_cnt[k] == TD - 1) begin
                            m_cnt[k] = 0;
                            m_rem[k] = m_rem[k] - 1;
                            if (m_rem[k] == 0) m_state[k] = M_DONE;
                            else if (s_p) m_state[k] = M_PAUSE;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                            if (s_p) m_state[k] = M_PAUSE;
                        end
                    end
                    M_PAUSE: begin
                        if (s_p) m_state[k] = M_RUN;
                    end
                    default: begin
                        m_rem[k] = 0;
                        m_cnt[k] = 0;
                        if (s_p) begin
                            m_state[k] = M_IDLE;
                            m_rem[k]   = preset[k];
                        end
                    end
                endcase
            end
        end
        s_deb = (s_run >= DEB);
        c_deb = (c_run >= DEB);
        s_p = s_deb && !s_deb_d;
        c_p = c_deb && !c_deb_d;
        s_deb_d = s_deb;
        c_deb_d = c_deb;
        s_run = s ? ((s_run < 1000) ? s_run + 1 : s_run) : 0;
        c_run = c ? ((c_run < 1000) ? c_run + 1 : c_run) : 0;
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("digits[%0d]", k), dut_dig(k), exp_dig(m_rem[k]));
            chk($sformatf("running[%0d]", k), int'(run_o[k]), int'(m_state[k] == M_RUN));
            chk($sformatf("done[%0d]", k), int'(done_o[k]), int'(m_state[k] == M_DONE));
        end
    endtask

    // Drive buttons, take one edge, advance the model, compare 1 time unit later.
    task automatic cyc(input logic s, input logic c);
        pb_start = s;
        pb_clr   = c;
        @(posedge clk_tmp);
        if (rst_n) model_step(s, c);
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic press(input logic s, input logic c, input int n);
        for (int i = 0; i < n; i++) cyc(s, c);
        cyc(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int saved;
        int toggles;
        bit prev_run;
        int held;
        int wait_n;

        rst_n = 1'b0;
        pb_start = 1'b0;
        pb_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_tmp);
        #1;
        check_all();
        chk("reset_digits", dut_dig(0), 16'h0130);
        chk("reset_running", int'(run_o[0]), 0);
        chk("reset_done", int'(done_o[0]), 0);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);

        // Bouncy press, then six stable highs: exactly one pulse, FSM reacts
        // on the fifth edge after the first stable high.
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0);
            chk("start_latency", int'(run_o[0]), (i == 5) ? 1 : 0);
        end
        // Preset 00:00 goes straight to DONE on that same edge.
        chk("zero_preset_done", int'(done_o[2]), 1);
        for (int j = 1; j <= 8; j++) begin
            cyc(1'b0, 1'b0);
            if (j == 4) begin
                chk("t3_one_sec", dut_dig(3), 16'h0001);
                chk("t1_borrow", dut_dig(1), 16'h0959);
                chk("t0_first_dec", dut_dig(0), 16'h0129);
            end
            if (j == 7) chk("t3_run_before", int'(run_o[3]), 1);
            if (j == 8) begin
                chk("t3_zero", dut_dig(3), 16'h0000);
                chk("t3_done", int'(done_o[3]), 1);
                chk("t3_run_drop", int'(run_o[3]), 0);
            end
        end

        // Run down through 01:00 -> 00:59 on the way to 01:17? no: stop at 01:17.
        wait_n = 0;
        while (dut_dig(0) != 16'h0117 && wait_n < 400) begin
            cyc(1'b0, 1'b0);
            wait_n++;
        end
        chk("reach_0117", dut_dig(0), 16'h0117);
        async_reset();
        chk("rst_mid_run_digits", dut_dig(0), 16'h0130);
        chk("rst_mid_run_running", int'(run_o[0]), 0);
        repeat (10) cyc(1'b0, 1'b0);

        // Start again and hold the button for 50 cycles: a single toggle.
        toggles = 0;
        prev_run = run_o[0];
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b0);
            if (run_o[0] != prev_run) toggles++;
            prev_run = run_o[0];
        end
        repeat (3) begin
            cyc(1'b0, 1'b0);
            if (run_o[0] != prev_run) toggles++;
            prev_run = run_o[0];
        end
        chk("held_single_pulse", toggles, 1);

        // Pause so the prescaler holds 2 of 4, wait 20 cycles, then resume.
        wait_n = 0;
        while (m_cnt[0] != 0 && wait_n < 10) begin
            cyc(1'b0, 1'b0);
            wait_n++;
        end
        press(1'b1, 1'b0, 5);
        chk("paused", int'(run_o[0]), 0);
        held = m_cnt[0];
        saved = m_rem[0];
        repeat (20) cyc(1'b0, 1'b0);
        chk("pause_frozen", dut_dig(0), exp_dig(saved));
        press(1'b1, 1'b0, 5);
        chk("resumed", int'(run_o[0]), 1);
        chk("held_count", held, 2);
        cyc(1'b0, 1'b0);
        chk("resume_no_dec_yet", dut_dig(0), exp_dig(saved));
        cyc(1'b0, 1'b0);
        chk("resume_dec_2cyc", dut_dig(0), exp_dig(saved - 1));

        // 01:00 -> 00:59 borrow on the 01:30 timer.
        wait_n = 0;
        while (dut_dig(0) != 16'h0100 && wait_n < 400) begin
            cyc(1'b0, 1'b0);
            wait_n++;
        end
        chk("reach_0100", dut_dig(0), 16'h0100);
        repeat (TD) cyc(1'b0, 1'b0);
        chk("borrow_0059", dut_dig(0), 16'h0059);

        // start and clear together while running: clear wins.
        press(1'b1, 1'b1, 6);
        chk("clr_wins_running", int'(run_o[0]), 0);
        chk("clr_wins_preset", dut_dig(0), 16'h0130);

        // Randomised phase.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                repeat ($urandom_range(1, 60)) cyc(1'b0, 1'b0);
            end else if (r < 85) begin
                repeat ($urandom_range(0, 4)) cyc(1'($urandom_range(0, 1)), 1'b0);
                press(1'b1, 1'b0, int'($urandom_range(1, 8)));
            end else if (r < 97) begin
                repeat ($urandom_range(0, 3)) cyc(1'b0, 1'($urandom_range(0, 1)));
                press(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 7)));
            end else begin
                async_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lab6_countdown_timer.md
Name: lab6_countdown_timer

Overview:
- Minute:second countdown timer running in the slow clock domain produced by the lab6 frequency divider, clocked by clk_tmp (nominally 100 Hz).
- Debounces and one-pulses two raw pushbuttons (start/pause, clear), prescales clk_tmp to a 1 s tick, and counts a BCD MM:SS value down to 00:00.
- Its four BCD digit outputs feed the seven-segment scan/decoder stage downstream.

Parameters:
- TICK_DIV, 100, clk_tmp cycles per 1 s tick (legal 1..1023).
- DEB_LEN, 4, consecutive high samples required to accept a button press (legal 2..8).
- INIT_MIN, 1, preset minutes, decimal 0..99.
- INIT_SEC, 30, preset seconds, decimal 0..59.

Ports:
- clk_tmp  input  1  slow clock from the divider; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- pb_start  input  1  raw start/pause pushbutton, active-high, may bounce.
- pb_clr  input  1  raw clear pushbutton, active-high, may bounce.
- min_tens  output  4  BCD minutes tens digit.
- min_ones  output  4  BCD minutes ones digit.
- sec_tens  output  4  BCD seconds tens digit (0..5).
- sec_ones  output  4  BCD seconds ones digit.
- running  output  1  high in RUN state.
- done  output  1  high in DONE state.

Behaviour:
- Reset (rst_n=0, async):
  - State = IDLE; digits = preset (INIT_MIN/10, INIT_MIN%10, INIT_SEC/10, INIT_SEC%10).
  - running=0, done=0.
  - Tick counter = 0; debounce shift registers and pulse registers all 0.
- Debounce, per button:
  - DEB_LEN-bit shift register samples the raw input each edge.
  - deb = AND of all bits; deb_d = deb delayed one edge.
  - Registered pulse = deb & ~deb_d, high for exactly one cycle per accepted press.
  - Timing: if the input is high at edges n..n+DEB_LEN-1, the pulse is high from edge n+DEB_LEN to edge n+DEB_LEN+1, and the FSM acts on it at edge n+DEB_LEN+1.
  - Any low sample restarts the qualification window.
  - Holding the button gives a single pulse.
- Tick counter:
  - Width max(1, clog2(TICK_DIV)); counts 0..TICK_DIV-1 only in RUN.
  - Holds its value in PAUSE; cleared to 0 in IDLE and DONE.
  - tick = (RUN && cnt==TICK_DIV-1); the counter wraps to 0 on the tick edge.
- FSM (clr_pulse has priority over start_pulse in every state):
  - IDLE: digits = preset. start_pulse -> RUN, or -> DONE directly if preset is 00:00.
  - RUN: on tick, BCD-decrement the digits. start_pulse -> PAUSE.
  - PAUSE: digits and tick counter frozen. start_pulse -> RUN; the tick counter resumes from its held value.
  - DONE: digits 00:00, done=1. start_pulse -> IDLE (preset reloaded).
  - clr_pulse in any state -> IDLE with preset reloaded and tick counter cleared, on the same edge.
- BCD decrement, ripple borrow:
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements by the borrow.
  - If the result is 00:00, the same edge moves to DONE.
  - Decrement from 00:00 never occurs (no wrap to 99:59).
- Outputs: running = (state==RUN), done = (state==DONE); both registered, glitch-free.
- Simultaneous tick and start_pulse in RUN: the decrement is applied and the state becomes PAUSE on the same edge.

Test Plan:
- Reset mid-RUN at 01:17 -> digits return to 01:30 immediately, asynchronously; running=0; no pulse issued after reset release until a fresh DEB_LEN-qualified press.
- pb_start bounce 1,0,1,1,0 then held high 6 cycles (DEB_LEN=4) -> exactly one start_pulse, 4 edges after the first of the stable highs; held high 50 cycles -> still one pulse.
- TICK_DIV=4, preset 00:02, start -> 00:01 after 4 cycles, 00:00 and done=1 after 8; running drops on the same edge.
- Borrow chain: preset 10:00, one tick -> 09:59; preset 01:00 -> 00:59.
- Pause at tick count 2 of 4, hold 20 cycles -> digits unchanged; resume -> next decrement exactly 2 cycles later.
- start and clr pressed in the same cycle while in RUN -> IDLE, preset shown, running=0; preset 00:00 with start -> DONE with no tick.
